// File: rtl/t_ff_response_checker.sv
// t_ff_response_checker: lockstep T-FF golden model that checks DUT q, counts faults and captures the first failing cycle.
// Optional MISR signature of dut_q when T_FF_CHK_MISR_EN is defined.
module t_ff_response_checker #(
  parameter int CNT_W  = 8,
  parameter int CYC_W  = 16,
  parameter int MISR_W = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [CYC_W-1:0]  run_len,
  input  logic              obs_t,
  input  logic              obs_clear,
  input  logic              dut_q,
  output logic              busy,
  output logic              done,
  output logic              sync_err,
  output logic              fault_pulse,
  output logic              fault_indicator,
  output logic [CNT_W-1:0]  fault_count,
  output logic              first_fail_valid,
  output logic [CYC_W-1:0]  first_fail_cyc,
  output logic [MISR_W-1:0] signature
);
  typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} state_e;
  state_e            state_q;
  logic              model_q, done_q, sync_err_q, pulse_q, ind_q, ffv_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CYC_W-1:0]  cyc_q, len_q, ffc_q;
  logic              mismatch, last;
  // X/Z on dut_q must count as a fault, hence the case inequality
  assign mismatch = dut_q !== model_q;
  assign last     = cyc_q == len_q - CYC_W'(1);
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      model_q    <= 1'b0;
      done_q     <= 1'b0;
      sync_err_q <= 1'b0;
      pulse_q    <= 1'b0;
      ind_q      <= 1'b0;
      ffv_q      <= 1'b0;
      cnt_q      <= '0;
      cyc_q      <= '0;
      len_q      <= '0;
      ffc_q      <= '0;
    end else begin
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          len_q      <= run_len;
          cyc_q      <= '0;
          cnt_q      <= '0;
          ind_q      <= 1'b0;
          ffv_q      <= 1'b0;
          ffc_q      <= '0;
          sync_err_q <= 1'b0;
          state_q    <= run_len == '0 ? DONE : SYNC;
          done_q     <= run_len == '0;
        end
        SYNC: if (obs_clear) begin
          model_q <= 1'b0;
          cyc_q   <= '0;
          state_q <= CHECK;
        end else if (last) begin
          sync_err_q <= 1'b1;
          done_q     <= 1'b1;
          state_q    <= DONE;
        end else begin
          cyc_q <= cyc_q + CYC_W'(1);
        end
        CHECK: begin
          if (mismatch) begin
            pulse_q <= 1'b1;
            ind_q   <= 1'b1;
            if (~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
            if (!ffv_q) begin
              ffv_q <= 1'b1;
              ffc_q <= cyc_q;
            end
          end
          model_q <= obs_clear ? 1'b0 : model_q ^ obs_t;
          cyc_q   <= cyc_q + CYC_W'(1);
          if (last) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy             = state_q == SYNC || state_q == CHECK;
  assign done             = done_q;
  assign sync_err         = sync_err_q;
  assign fault_pulse      = pulse_q;
  assign fault_indicator  = ind_q;
  assign fault_count      = cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_cyc   = ffc_q;
`ifdef T_FF_CHK_MISR_EN
  localparam logic [MISR_W-1:0] POLY = MISR_W'(16'h100B);
  logic [MISR_W-1:0] sig_q;
  always_ff @(posedge clk) begin
    if (clear || (state_q == IDLE && start)) sig_q <= '0;
    else if (state_q == CHECK) sig_q <= {sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? POLY : '0) ^ MISR_W'(dut_q);
  end
  assign signature = sig_q;
`else
  assign signature = '0;
`endif
endmodule

// File: tb/tb_t_ff_response_checker.sv
// tb_t_ff_response_checker: randomized scenarios against a trace-level reference of the checker rules.
module tb_t_ff_response_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clear, start, obs_t, obs_clear, dut_q;
  logic [15:0] run_len;
  logic busy, done, sync_err, fault_pulse, fault_indicator, first_fail_valid;
  logic [7:0] fault_count;
  logic [15:0] first_fail_cyc, signature;
  logic s_busy, s_done, s_sync_err, s_pulse, s_ind, s_ffv;
  logic [1:0] s_cnt;
  logic [15:0] s_ffc, s_sig;
  int checks = 0, errors = 0;
  logic tv[128], cv[128], qv[128];
  int e_cnt, e_ffc, e_done, o_done;
  logic e_sync;
  logic [127:0] e_pulses, o_pulses;
  logic [15:0] e_sig;
`ifdef T_FF_CHK_MISR_EN
  localparam bit MISR_ON = 1'b1;
`else
  localparam bit MISR_ON = 1'b0;
`endif

  t_ff_response_checker u_dut (
    .clk(clk), .clear(clear), .start(start), .run_len(run_len),
    .obs_t(obs_t), .obs_clear(obs_clear), .dut_q(dut_q),
    .busy(busy), .done(done), .sync_err(sync_err), .fault_pulse(fault_pulse),
    .fault_indicator(fault_indicator), .fault_count(fault_count),
    .first_fail_valid(first_fail_valid), .first_fail_cyc(first_fail_cyc), .signature(signature)
  );
  t_ff_response_checker #(.CNT_W(2)) u_sat (
    .clk(clk), .clear(clear), .start(start), .run_len(run_len),
    .obs_t(obs_t), .obs_clear(obs_clear), .dut_q(dut_q),
    .busy(s_busy), .done(s_done), .sync_err(s_sync_err), .fault_pulse(s_pulse),
    .fault_indicator(s_ind), .fault_count(s_cnt),
    .first_fail_valid(s_ffv), .first_fail_cyc(s_ffc), .signature(s_sig)
  );

  // s: first obs_clear index (-1 none); tmode 0 rand,1 every 3rd,2 zero,3 one; fmode 0 good,1 sa1,2 sa0,3 rand flips,4 rand X
  task automatic gen(input int s, input int tmode, input int fmode, input int flipj);
    logic dq;
    dq = 1'($urandom);
    for (int e = 0; e < 128; e++) begin
      cv[e] = (e == s) || (tmode == 0 && s >= 0 && e > s && $urandom_range(0, 9) == 0);
      tv[e] = tmode == 0 ? 1'($urandom) : tmode == 1 ? (e % 3 == 0) : (tmode == 3);
      qv[e] = fmode == 1 ? 1'b1 : fmode == 2 ? 1'b0 : dq;
      if (flipj >= 0 && e == s + 1 + flipj) qv[e] = ~dq;
      if (fmode == 3 && $urandom_range(0, 7) == 0) qv[e] = ~dq;
      if (fmode == 4 && $urandom_range(0, 7) == 0) qv[e] = 1'bx;
      dq = cv[e] ? 1'b0 : dq ^ tv[e];
    end
  endtask

  task automatic ref_model(input int len);
    int s;
    logic m;
    s = -1; m = 1'b0;
    e_cnt = 0; e_ffc = 0; e_sync = 1'b0; e_pulses = '0; e_sig = '0;
    if (len == 0) begin e_done = -1; return; end
    for (int e = 0; e < len && s < 0; e++) if (cv[e]) s = e;
    if (s < 0) begin e_sync = 1'b1; e_done = len - 1; return; end
    e_done = s + len;
    for (int j = 0; j < len; j++) begin
      int e;
      e = s + 1 + j;
      if (qv[e] !== m) begin
        if (e_cnt == 0) e_ffc = j;
        e_cnt++;
        e_pulses[e] = 1'b1;
      end
      e_sig = {e_sig[14:0], 1'b0} ^ (e_sig[15] ? 16'h100B : 16'h0) ^ {15'b0, qv[e]};
      m = cv[e] ? 1'b0 : m ^ tv[e];
    end
    if (!MISR_ON) e_sig = '0;
  endtask

  // bs: edge index at which a stray start is pulsed (-1 none)
  task automatic drive_run(input int len, input int bs);
    o_done = -2; o_pulses = '0;
    @(negedge clk); start = 1'b1; run_len = 16'(len);
    @(negedge clk); start = 1'b0;
    if (done) o_done = -1;
    for (int e = 0; e < 100 && o_done == -2; e++) begin
      obs_t = tv[e]; obs_clear = cv[e]; dut_q = qv[e];
      start = (e == bs); run_len = (e == bs) ? 16'd3 : 16'(len);
      @(negedge clk);
      start = 1'b0;
      o_pulses[e] = fault_pulse;
      if (done) o_done = e;
    end
  endtask

  task automatic test_reset;
    clear = 1'b1; start = 1'b0; obs_t = 1'b0; obs_clear = 1'b0; dut_q = 1'b0; run_len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sync_err, fault_pulse, fault_indicator, first_fail_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000", {busy, done, sync_err, fault_pulse, fault_indicator, first_fail_valid});
    end
    checks++;
    if (fault_count !== 8'd0 || first_fail_cyc !== 16'd0 || signature !== 16'd0) begin
      errors++; $display("FAIL reset_regs got cnt=%0d ffc=%0d sig=%h want 0", fault_count, first_fail_cyc, signature);
    end
    clear = 1'b0;
  endtask

  task automatic test_fault_free;
    gen(1, 1, 0, -1); drive_run(20, -1); ref_model(20);
    checks++;
    if (o_done !== e_done) begin errors++; $display("FAIL ff_done got %0d want %0d", o_done, e_done); end
    checks++;
    if (fault_count !== 8'd0 || fault_indicator !== 1'b0 || sync_err !== 1'b0) begin
      errors++; $display("FAIL ff_result got cnt=%0d ind=%b se=%b want 0 0 0", fault_count, fault_indicator, sync_err);
    end
    checks++;
    if (signature !== e_sig) begin errors++; $display("FAIL ff_sig got %h want %h", signature, e_sig); end
  endtask

  task automatic test_stuck1;
    gen(0, 2, 1, -1); drive_run(10, -1); ref_model(10);
    checks++;
    if (o_done !== 10) begin errors++; $display("FAIL sa1_done got %0d want 10", o_done); end
    checks++;
    if (fault_count !== 8'd10) begin errors++; $display("FAIL sa1_count got %0d want 10", fault_count); end
    checks++;
    if (first_fail_valid !== 1'b1 || first_fail_cyc !== 16'd0) begin
      errors++; $display("FAIL sa1_first got v=%b cyc=%0d want 1 0", first_fail_valid, first_fail_cyc);
    end
    checks++;
    if (s_cnt !== 2'd3) begin errors++; $display("FAIL sa1_sat got %0d want 3", s_cnt); end
  endtask

  task automatic test_flip7;
    gen(2, 0, 0, 7); drive_run(16, -1); ref_model(16);
    checks++;
    if ($countones(o_pulses) != 1 || o_pulses !== e_pulses) begin
      errors++; $display("FAIL flip_pulses got %h want %h", o_pulses, e_pulses);
    end
    checks++;
    if (first_fail_cyc !== 16'd7 || fault_count !== 8'd1) begin
      errors++; $display("FAIL flip_first got cyc=%0d cnt=%0d want 7 1", first_fail_cyc, fault_count);
    end
    checks++;
    if (fault_indicator !== 1'b1 || o_done !== e_done) begin
      errors++; $display("FAIL flip_end got ind=%b done=%0d want 1 %0d", fault_indicator, o_done, e_done);
    end
  endtask

  task automatic test_no_sync;
    gen(-1, 0, 3, -1); drive_run(5, -1);
    checks++;
    if (o_done !== 4) begin errors++; $display("FAIL nosync_done got %0d want 4", o_done); end
    checks++;
    if (sync_err !== 1'b1 || fault_count !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL nosync_result got se=%b cnt=%0d busy=%b want 1 0 0", sync_err, fault_count, busy);
    end
  endtask

  task automatic test_saturate;
    gen(0, 3, 2, -1); drive_run(12, -1); ref_model(12);
    checks++;
    if (s_cnt !== 2'd3) begin errors++; $display("FAIL sat_count got %0d want 3", s_cnt); end
    checks++;
    if (fault_count !== 8'(e_cnt)) begin errors++; $display("FAIL sat_wide got %0d want %0d", fault_count, e_cnt); end
  endtask

  task automatic test_len0;
    gen(0, 0, 1, -1); drive_run(0, -1);
    checks++;
    if (o_done !== -1) begin errors++; $display("FAIL len0_done got %0d want -1", o_done); end
    checks++;
    if (sync_err !== 1'b0 || fault_count !== 8'd0 || first_fail_valid !== 1'b0) begin
      errors++; $display("FAIL len0_result got se=%b cnt=%0d ffv=%b want 0 0 0", sync_err, fault_count, first_fail_valid);
    end
  endtask

  task automatic test_clear_abort;
    bit saw_done;
    gen(0, 2, 1, -1);
    @(negedge clk); start = 1'b1; run_len = 16'd20;
    @(negedge clk); start = 1'b0;
    for (int e = 0; e < 5; e++) begin
      obs_t = tv[e]; obs_clear = cv[e]; dut_q = qv[e];
      @(negedge clk);
    end
    checks++;
    if (fault_count !== 8'd4) begin errors++; $display("FAIL abort_pre got %0d want 4", fault_count); end
    clear = 1'b1; obs_t = tv[5]; obs_clear = cv[5]; dut_q = qv[5];
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if ({busy, done, sync_err, fault_pulse, fault_indicator, first_fail_valid} !== 6'b0 ||
        fault_count !== 8'd0 || first_fail_cyc !== 16'd0 || signature !== 16'd0) begin
      errors++; $display("FAIL abort_zero got busy=%b done=%b cnt=%0d ffc=%0d", busy, done, fault_count, first_fail_cyc);
    end
    saw_done = 1'b0;
    repeat (6) begin @(negedge clk); saw_done |= done | busy; end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_quiet got activity=1 want 0"); end
  endtask

  task automatic test_start_busy;
    gen(1, 0, 3, -1); drive_run(15, 5); ref_model(15);
    checks++;
    if (o_done !== e_done || o_pulses !== e_pulses) begin
      errors++; $display("FAIL busy_start got done=%0d want %0d", o_done, e_done);
    end
    checks++;
    if (fault_count !== 8'(e_cnt)) begin errors++; $display("FAIL busy_count got %0d want %0d", fault_count, e_cnt); end
    start = 1'b1; run_len = 16'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fault_count !== 8'(e_cnt)) begin
      errors++; $display("FAIL done_start got busy=%b done=%b cnt=%0d want 0 0 %0d", busy, done, fault_count, e_cnt);
    end
  endtask

  task automatic test_misr;
    logic [15:0] sig_a;
    gen(1, 1, 0, -1); drive_run(16, -1); ref_model(16);
    sig_a = signature;
    checks++;
    if (sig_a !== e_sig) begin errors++; $display("FAIL misr_model got %h want %h", sig_a, e_sig); end
    gen(1, 1, 0, -1); drive_run(16, -1);
    checks++;
    if (signature !== sig_a) begin errors++; $display("FAIL misr_repeat got %h want %h", signature, sig_a); end
`ifdef T_FF_CHK_MISR_EN
    checks++;
    if (sig_a === 16'd0) begin errors++; $display("FAIL misr_nonzero got %h want nonzero", sig_a); end
    gen(1, 1, 0, 7); drive_run(16, -1);
    checks++;
    if (signature === sig_a) begin errors++; $display("FAIL misr_flip got %h want different from %h", signature, sig_a); end
`endif
  endtask

  task automatic test_random;
    for (int it = 0; it < 25; it++) begin
      int len, s, fm;
      len = $urandom_range(1, 30);
      s = $urandom_range(0, len + 2);
      fm = $urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1) == 0 ? 3 : 4);
      gen(s, 0, fm, -1); drive_run(len, -1); ref_model(len);
      checks++;
      if (o_done !== e_done || o_pulses !== e_pulses) begin
        errors++; $display("FAIL rand%0d_timing got done=%0d pulses=%h want %0d %h", it, o_done, o_pulses, e_done, e_pulses);
      end
      checks++;
      if (fault_count !== 8'(e_cnt) || s_cnt !== 2'(e_cnt > 3 ? 3 : e_cnt) || fault_indicator !== (e_cnt > 0)) begin
        errors++; $display("FAIL rand%0d_count got %0d/%0d ind=%b want %0d", it, fault_count, s_cnt, fault_indicator, e_cnt);
      end
      checks++;
      if (first_fail_valid !== (e_cnt > 0) || first_fail_cyc !== 16'(e_ffc) || sync_err !== e_sync) begin
        errors++; $display("FAIL rand%0d_first got v=%b cyc=%0d se=%b want %b %0d %b", it,
                           first_fail_valid, first_fail_cyc, sync_err, e_cnt > 0, e_ffc, e_sync);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fault_free;
    test_stuck1;
    test_flip7;
    test_no_sync;
    test_saturate;
    test_len0;
    test_clear_abort;
    test_start_busy;
    test_misr;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
